// File: rtl/e203_exu_longp_wbq.sv
// Long-pipe write-back queue.
// Buffers LSU responses in a small circular FIFO and pairs the head entry with
// the OITF retire entry. A matched head leaves as a write-back request, an
// exception request, or a silent retire when the instruction writes no rd.
module e203_exu_longp_wbq #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int ITAG_W  = 1,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  // LSU response side
  input  logic               lsu_wbck_i_valid,
  output logic               lsu_wbck_i_ready,
  input  logic [XLEN-1:0]    lsu_wbck_i_wdat,
  input  logic [ITAG_W-1:0]  lsu_wbck_i_itag,
  input  logic               lsu_wbck_i_err,
  // OITF head
  input  logic               oitf_empty,
  input  logic [ITAG_W-1:0]  oitf_ret_ptr,
  input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
  input  logic               oitf_ret_rdwen,
  input  logic               oitf_ret_rdfpu,
  output logic               oitf_ret_ena,
  // Write-back arbiter side
  output logic               longp_wbck_o_valid,
  input  logic               longp_wbck_o_ready,
  output logic [XLEN-1:0]    longp_wbck_o_wdat,
  output logic [4:0]         longp_wbck_o_flags,
  output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
  output logic               longp_wbck_o_rdfpu,
  // Commit (exception) side
  output logic               longp_excp_o_valid,
  input  logic               longp_excp_o_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage; only the head slot is ever read.
  logic [XLEN-1:0]   wdat_mem [DEPTH];
  logic [ITAG_W-1:0] itag_mem [DEPTH];
  logic              err_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              head_match;
  logic [XLEN-1:0]   head_wdat;
  logic [ITAG_W-1:0] head_itag;
  logic              head_err;

  // Ready is a function of registered occupancy only, so it never depends
  // on downstream ready and a full queue refuses a push even while popping.
  assign full             = (count_reg == CNT_W'(DEPTH));
  assign empty            = (count_reg == '0);
  assign lsu_wbck_i_ready = ~full;
  assign push             = lsu_wbck_i_valid & lsu_wbck_i_ready;

  assign head_wdat = wdat_mem[rd_ptr_reg];
  assign head_itag = itag_mem[rd_ptr_reg];
  assign head_err  = err_mem[rd_ptr_reg];

  // The head may only leave when it belongs to the instruction at the OITF head.
  assign head_match = ~empty & ~oitf_empty & (head_itag == oitf_ret_ptr);

  // Per-slot write ports: a slot is loaded when the write pointer points at it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the LSU response into this slot on a push.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          wdat_mem[gi] <= lsu_wbck_i_wdat;
          itag_mem[gi] <= lsu_wbck_i_itag;
          err_mem[gi]  <= lsu_wbck_i_err;
        end
      end
    end
  endgenerate

  // Route the matched head to exactly one of: exception, write-back, silent retire.
  always_comb begin
    longp_excp_o_valid = 1'b0;
    longp_wbck_o_valid = 1'b0;
    pop                = 1'b0;
    if (head_match) begin
      if (head_err) begin
        longp_excp_o_valid = 1'b1;
        pop                = longp_excp_o_ready;
      end else if (oitf_ret_rdwen) begin
        longp_wbck_o_valid = 1'b1;
        pop                = longp_wbck_o_ready;
      end else begin
        pop                = 1'b1;
      end
    end
  end

  // Payload is forced to zero whenever no write-back is being requested.
  assign longp_wbck_o_wdat  = longp_wbck_o_valid ? head_wdat      : '0;
  assign longp_wbck_o_rdidx = longp_wbck_o_valid ? oitf_ret_rdidx : '0;
  assign longp_wbck_o_rdfpu = longp_wbck_o_valid & oitf_ret_rdfpu;
  assign longp_wbck_o_flags = 5'd0;
  assign oitf_ret_ena       = pop;

  // Pointer and occupancy updates; power-of-two depth makes the wrap implicit.
  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Queue control state; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_e203_exu_longp_wbq.sv
// Bench for the long-pipe write-back queue: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_e203_exu_longp_wbq;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;
  localparam int ITAG_W  = 1;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               lsu_wbck_i_valid;
  logic               lsu_wbck_i_ready;
  logic [XLEN-1:0]    lsu_wbck_i_wdat;
  logic [ITAG_W-1:0]  lsu_wbck_i_itag;
  logic               lsu_wbck_i_err;
  logic               oitf_empty;
  logic [ITAG_W-1:0]  oitf_ret_ptr;
  logic [RFIDX_W-1:0] oitf_ret_rdidx;
  logic               oitf_ret_rdwen;
  logic               oitf_ret_rdfpu;
  logic               oitf_ret_ena;
  logic               longp_wbck_o_valid;
  logic               longp_wbck_o_ready;
  logic [XLEN-1:0]    longp_wbck_o_wdat;
  logic [4:0]         longp_wbck_o_flags;
  logic [RFIDX_W-1:0] longp_wbck_o_rdidx;
  logic               longp_wbck_o_rdfpu;
  logic               longp_excp_o_valid;
  logic               longp_excp_o_ready;

  e203_exu_longp_wbq #(
    .XLEN(XLEN), .RFIDX_W(RFIDX_W), .ITAG_W(ITAG_W), .DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .lsu_wbck_i_valid   (lsu_wbck_i_valid),
    .lsu_wbck_i_ready   (lsu_wbck_i_ready),
    .lsu_wbck_i_wdat    (lsu_wbck_i_wdat),
    .lsu_wbck_i_itag    (lsu_wbck_i_itag),
    .lsu_wbck_i_err     (lsu_wbck_i_err),
    .oitf_empty         (oitf_empty),
    .oitf_ret_ptr       (oitf_ret_ptr),
    .oitf_ret_rdidx     (oitf_ret_rdidx),
    .oitf_ret_rdwen     (oitf_ret_rdwen),
    .oitf_ret_rdfpu     (oitf_ret_rdfpu),
    .oitf_ret_ena       (oitf_ret_ena),
    .longp_wbck_o_valid (longp_wbck_o_valid),
    .longp_wbck_o_ready (longp_wbck_o_ready),
    .longp_wbck_o_wdat  (longp_wbck_o_wdat),
    .longp_wbck_o_flags (longp_wbck_o_flags),
    .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
    .longp_wbck_o_rdfpu (longp_wbck_o_rdfpu),
    .longp_excp_o_valid (longp_excp_o_valid),
    .longp_excp_o_ready (longp_excp_o_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  typedef struct {
    logic [XLEN-1:0]   wdat;
    logic [ITAG_W-1:0] itag;
    logic              err;
  } ent_t;

  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: head leaves only when it carries the OITF head's tag.
  function automatic bit m_match();
    if (mq.size() == 0 || oitf_empty) return 1'b0;
    return mq[0].itag == oitf_ret_ptr;
  endfunction

  function automatic bit m_excp();
    return m_match() && mq[0].err;
  endfunction

  function automatic bit m_wbck();
    return m_match() && !mq[0].err && oitf_ret_rdwen;
  endfunction

  function automatic bit m_pop();
    if (!m_match()) return 1'b0;
    if (mq[0].err) return longp_excp_o_ready;
    if (oitf_ret_rdwen) return longp_wbck_o_ready;
    return 1'b1;
  endfunction

  // Model state advance at each active edge.
  always @(posedge clk) begin
    bit p;
    bit pu;
    ent_t e;
    started = 1'b1;
    if (rst) begin
      mq.delete();
    end else begin
      p  = m_pop();
      pu = lsu_wbck_i_valid && (mq.size() < DEPTH);
      e.wdat = lsu_wbck_i_wdat;
      e.itag = lsu_wbck_i_itag;
      e.err  = lsu_wbck_i_err;
      if (p) void'(mq.pop_front());
      if (pu) mq.push_back(e);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("lsu_ready", lsu_wbck_i_ready, mq.size() < DEPTH);
      chk("wbck_valid", longp_wbck_o_valid, m_wbck());
      chk("excp_valid", longp_excp_o_valid, m_excp());
      chk("ret_ena", oitf_ret_ena, m_pop());
      chk("flags", longp_wbck_o_flags, 0);
      if (m_wbck()) begin
        chk("wdat", longp_wbck_o_wdat, mq[0].wdat);
        chk("rdidx", longp_wbck_o_rdidx, oitf_ret_rdidx);
        chk("rdfpu", longp_wbck_o_rdfpu, oitf_ret_rdfpu);
      end else if (mq.size() == 0) begin
        chk("wdat_idle", longp_wbck_o_wdat, 0);
        chk("rdidx_idle", longp_wbck_o_rdidx, 0);
        chk("rdfpu_idle", longp_wbck_o_rdfpu, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lsu(input logic v, input logic [31:0] d, input logic t, input logic e);
    lsu_wbck_i_valid = v;
    lsu_wbck_i_wdat  = d;
    lsu_wbck_i_itag  = t;
    lsu_wbck_i_err   = e;
  endtask

  initial begin
    rst                = 1'b1;
    drive_lsu(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    oitf_empty         = 1'b1;
    oitf_ret_ptr       = '0;
    oitf_ret_rdidx     = '0;
    oitf_ret_rdwen     = 1'b0;
    oitf_ret_rdfpu     = 1'b0;
    longp_wbck_o_ready = 1'b0;
    longp_excp_o_ready = 1'b0;

    // Reset held two cycles with a pending response.
    tick();
    tick();
    rst = 1'b0;
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[%0t] reset released", $time);
    chk("rst_lsu_ready", lsu_wbck_i_ready, 1);
    chk("rst_wbck_valid", longp_wbck_o_valid, 0);
    chk("rst_excp_valid", longp_excp_o_valid, 0);
    chk("rst_ret_ena", oitf_ret_ena, 0);
    chk("rst_wdat", longp_wbck_o_wdat, 0);

    // Single load, accepted immediately.
    tick();
    oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_rdidx = 5'd5; oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b1;
    drive_lsu(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[%0t] single load 0xdeadbeef -> x5", $time);
    chk("ld_valid", longp_wbck_o_valid, 1);
    chk("ld_wdat", longp_wbck_o_wdat, 32'hDEAD_BEEF);
    chk("ld_rdidx", longp_wbck_o_rdidx, 5);
    chk("ld_flags", longp_wbck_o_flags, 0);
    chk("ld_ret_ena", oitf_ret_ena, 1);
    tick();

    // Backpressure: three stalled cycles, then a single pop.
    longp_wbck_o_ready = 1'b0;
    drive_lsu(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", longp_wbck_o_valid, 1);
      chk("bp_wdat", longp_wbck_o_wdat, 32'hCAFE_F00D);
      chk("bp_ret_ena", oitf_ret_ena, 0);
      tick();
    end
    longp_wbck_o_ready = 1'b1;
    @(negedge clk);
    $display("[%0t] backpressure released", $time);
    chk("bp_pop", oitf_ret_ena, 1);
    tick();
    @(negedge clk);
    chk("bp_ret_once", oitf_ret_ena, 0);
    chk("bp_valid_drop", longp_wbck_o_valid, 0);

    // Error response routed to the exception port.
    oitf_ret_ptr = 1'b1;
    drive_lsu(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[%0t] error response itag=1", $time);
    chk("err_excp", longp_excp_o_valid, 1);
    chk("err_wbck", longp_wbck_o_valid, 0);
    chk("err_hold", oitf_ret_ena, 0);
    tick();
    longp_excp_o_ready = 1'b1;
    @(negedge clk);
    chk("err_ret", oitf_ret_ena, 1);
    tick();
    longp_excp_o_ready = 1'b0;
    @(negedge clk);
    chk("err_done", longp_excp_o_valid, 0);

    // Fill the queue, stall a third response, then drain in order.
    oitf_ret_ptr = 1'b0;
    longp_wbck_o_ready = 1'b0;
    drive_lsu(1'b1, 32'hA0A0_A0A0, 1'b0, 1'b0);
    tick();
    drive_lsu(1'b1, 32'hB0B0_B0B0, 1'b0, 1'b0);
    tick();
    drive_lsu(1'b1, 32'hC0C0_C0C0, 1'b0, 1'b0);
    @(negedge clk);
    $display("[%0t] queue full, third response stalled", $time);
    chk("full_ready", lsu_wbck_i_ready, 0);
    tick();
    longp_wbck_o_ready = 1'b1;
    @(negedge clk);
    chk("full_head_a", longp_wbck_o_wdat, 32'hA0A0_A0A0);
    chk("full_pop_ready", lsu_wbck_i_ready, 0);
    tick();
    @(negedge clk);
    chk("full_head_b", longp_wbck_o_wdat, 32'hB0B0_B0B0);
    chk("full_reopen", lsu_wbck_i_ready, 1);
    chk("full_ret_b", oitf_ret_ena, 1);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_head_c", longp_wbck_o_wdat, 32'hC0C0_C0C0);
    tick();
    @(negedge clk);
    chk("full_drained", longp_wbck_o_valid, 0);

    // Tag mismatch holds the head; then a matched no-rdwen entry retires silently.
    drive_lsu(1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mm_valid", longp_wbck_o_valid, 0);
      chk("mm_ret", oitf_ret_ena, 0);
      tick();
    end
    oitf_ret_ptr = 1'b1;
    oitf_ret_rdwen = 1'b0;
    @(negedge clk);
    $display("[%0t] matched no-rdwen retire", $time);
    chk("nowen_ret", oitf_ret_ena, 1);
    chk("nowen_wbck", longp_wbck_o_valid, 0);
    tick();

    // Empty OITF blocks a matching head.
    oitf_ret_rdwen = 1'b1;
    oitf_empty = 1'b1;
    drive_lsu(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("oe_valid", longp_wbck_o_valid, 0);
    oitf_empty = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-operation discards the queued entry without retiring it.
    longp_wbck_o_ready = 1'b0;
    drive_lsu(1'b1, 32'h7777_7777, 1'b1, 1'b0);
    tick();
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    longp_wbck_o_ready = 1'b1;
    @(negedge clk);
    $display("[%0t] mid-run reset", $time);
    chk("mrst_valid", longp_wbck_o_valid, 0);
    chk("mrst_ret", oitf_ret_ena, 0);

    // Streaming: one response per cycle with ready high, model-checked.
    oitf_ret_ptr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      oitf_ret_rdidx = 5'(i + 3);
      oitf_ret_rdfpu = i[0];
      drive_lsu(1'b1, $urandom, 1'b0, 1'b0);
      $display("[%0t] stream push %0d wdat=%h", $time, i, lsu_wbck_i_wdat);
      tick();
    end
    drive_lsu(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
